mem_access: RTL and testbench

//  Memory-access stage: consumer of the registered exec->MA request bundle (CUSHION_* signals).

---
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_access.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and memory.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_strb, mem_wdata, mem_err,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_strb, mem_wdata, mem_err,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: issues stores/loads on the data bus, extracts and extends
// load data, forwards plain register writes and stalls upstream while busy.
module mem_access #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cushion_reg_w_valid,
  input  logic [4:0]          cushion_reg_w_rd,
  input  logic [31:0]         cushion_reg_w_data,
  input  logic                cushion_mem_r_valid,
  input  logic [4:0]          cushion_mem_r_rd,
  input  logic [31:0]         cushion_mem_r_addr,
  input  logic [3:0]          cushion_mem_r_strb,
  input  logic                cushion_mem_r_signed,
  input  logic                cushion_mem_w_valid,
  input  logic [31:0]         cushion_mem_w_addr,
  input  logic [3:0]          cushion_mem_w_strb,
  input  logic [31:0]         cushion_mem_w_data,
  output logic                stall,
  mem_access_if.master        bus,
  output logic                ma_reg_w_valid,
  output logic [4:0]          ma_reg_w_rd,
  output logic [31:0]         ma_reg_w_data
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

  state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic         ld_pend, ld_pend_n;
  logic [4:0]   r_rd, r_rd_n;
  logic [29:0]  r_word, r_word_n;
  logic [3:0]   r_strb, r_strb_n;
  logic         r_signed, r_signed_n;

  logic         req_q, req_n;
  logic         we_q, we_n;
  logic [31:0]  addr_q, addr_n;
  logic [3:0]   strb_q, strb_n;
  logic [31:0]  wdata_q, wdata_n;
  logic         err_q, err_n;
  logic         stall_n;
  logic         wb_valid_n;
  logic [4:0]   wb_rd_n;
  logic [31:0]  wb_data_n;

  // Byte-offset bits come from the lane mask, so address bits [1:0] are not needed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cushion_mem_r_addr[1:0], cushion_mem_w_addr[1:0]};

  function automatic logic strb_legal(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: strb_legal = 1'b1;
      default:                   strb_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] strb_shift(input logic [3:0] s);
    logic [1:0] off;
    if (s[0])      off = 2'd0;
    else if (s[1]) off = 2'd1;
    else if (s[2]) off = 2'd2;
    else           off = 2'd3;
    strb_shift = {off, 3'b000};
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [3:0] s,
                                               input logic sgn);
    logic [31:0] x;
    x = d >> strb_shift(s);
    case (s)
      4'b1111:          load_extract = x;
      4'b0011, 4'b1100: load_extract = sgn ? {{16{x[15]}}, x[15:0]} : {16'b0, x[15:0]};
      default:          load_extract = sgn ? {{24{x[7]}}, x[7:0]} : {24'b0, x[7:0]};
    endcase
  endfunction

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_strb  = strb_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_err   = err_q;

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      ld_pend        <= 1'b0;
      r_rd           <= '0;
      r_word         <= '0;
      r_strb         <= '0;
      r_signed       <= 1'b0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      strb_q         <= '0;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      stall          <= 1'b0;
      ma_reg_w_valid <= 1'b0;
      ma_reg_w_rd    <= '0;
      ma_reg_w_data  <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      ld_pend        <= ld_pend_n;
      r_rd           <= r_rd_n;
      r_word         <= r_word_n;
      r_strb         <= r_strb_n;
      r_signed       <= r_signed_n;
      req_q          <= req_n;
      we_q           <= we_n;
      addr_q         <= addr_n;
      strb_q         <= strb_n;
      wdata_q        <= wdata_n;
      err_q          <= err_n;
      stall          <= stall_n;
      ma_reg_w_valid <= wb_valid_n;
      ma_reg_w_rd    <= wb_rd_n;
      ma_reg_w_data  <= wb_data_n;
    end
  end

  // Next-state and next-output decode; bus fields hold their value unless reloaded.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ld_pend_n  = ld_pend;
    r_rd_n     = r_rd;
    r_word_n   = r_word;
    r_strb_n   = r_strb;
    r_signed_n = r_signed;
    req_n      = 1'b0;
    we_n       = we_q;
    addr_n     = addr_q;
    strb_n     = strb_q;
    wdata_n    = wdata_q;
    err_n      = 1'b0;
    wb_valid_n = 1'b0;
    wb_rd_n    = ma_reg_w_rd;
    wb_data_n  = ma_reg_w_data;

    case (state)
      IDLE: begin
        if (cushion_reg_w_valid) begin
          wb_valid_n = (cushion_reg_w_rd != 5'd0);
          wb_rd_n    = cushion_reg_w_rd;
          wb_data_n  = cushion_reg_w_data;
        end
        if (cushion_mem_w_valid || cushion_mem_r_valid) begin
          if ((cushion_mem_w_valid && !strb_legal(cushion_mem_w_strb)) ||
              (cushion_mem_r_valid && !strb_legal(cushion_mem_r_strb))) begin
            err_n = 1'b1;
          end else begin
            ld_pend_n  = cushion_mem_r_valid;
            r_rd_n     = cushion_mem_r_rd;
            r_word_n   = cushion_mem_r_addr[31:2];
            r_strb_n   = cushion_mem_r_strb;
            r_signed_n = cushion_mem_r_signed;
            cnt_n      = '0;
            req_n      = 1'b1;
            if (cushion_mem_w_valid) begin
              state_n = WR;
              we_n    = 1'b1;
              addr_n  = {cushion_mem_w_addr[31:2], 2'b00};
              strb_n  = cushion_mem_w_strb;
              wdata_n = cushion_mem_w_data << strb_shift(cushion_mem_w_strb);
            end else begin
              state_n = RD;
              we_n    = 1'b0;
              addr_n  = {cushion_mem_r_addr[31:2], 2'b00};
              strb_n  = cushion_mem_r_strb;
            end
          end
        end
      end
      WR, RD: begin
        if (bus.mem_ack) begin
          cnt_n = '0;
          if (state == RD) begin
            wb_valid_n = (r_rd != 5'd0);
            wb_rd_n    = r_rd;
            wb_data_n  = load_extract(bus.mem_rdata, r_strb, r_signed);
            ld_pend_n  = 1'b0;
            state_n    = IDLE;
          end else if (ld_pend) begin
            state_n = RD;
            req_n   = 1'b1;
            we_n    = 1'b0;
            addr_n  = {r_word, 2'b00};
            strb_n  = r_strb;
          end else begin
            state_n = IDLE;
          end
        end else if (cnt == CNT_W'(WAIT_LIMIT - 1)) begin
          err_n     = 1'b1;
          ld_pend_n = 1'b0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          req_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    stall_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected write-backs and bus transfers are queued
// by the stimulus and popped by independent monitors.
module tb_mem_access;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  logic        clk;
  logic        rst_n;
  logic        reg_w_valid;
  logic [4:0]  reg_w_rd;
  logic [31:0] reg_w_data;
  logic        r_valid;
  logic [4:0]  r_rd;
  logic [31:0] r_addr;
  logic [3:0]  r_strb;
  logic        r_signed;
  logic        w_valid;
  logic [31:0] w_addr;
  logic [3:0]  w_strb;
  logic [31:0] w_data;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;
  wb_t  wb_q[$];
  bus_t bus_q[$];

  mem_access_if bus ();

  mem_access #(.WAIT_LIMIT(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cushion_reg_w_valid  (reg_w_valid),
    .cushion_reg_w_rd     (reg_w_rd),
    .cushion_reg_w_data   (reg_w_data),
    .cushion_mem_r_valid  (r_valid),
    .cushion_mem_r_rd     (r_rd),
    .cushion_mem_r_addr   (r_addr),
    .cushion_mem_r_strb   (r_strb),
    .cushion_mem_r_signed (r_signed),
    .cushion_mem_w_valid  (w_valid),
    .cushion_mem_w_addr   (w_addr),
    .cushion_mem_w_strb   (w_strb),
    .cushion_mem_w_data   (w_data),
    .stall                (stall),
    .bus                  (bus.master),
    .ma_reg_w_valid       (wb_valid),
    .ma_reg_w_rd          (wb_rd),
    .ma_reg_w_data        (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reg_w_valid = 1'b0; reg_w_rd = '0; reg_w_data = '0;
    r_valid = 1'b0; r_rd = '0; r_addr = '0; r_strb = '0; r_signed = 1'b0;
    w_valid = 1'b0; w_addr = '0; w_strb = '0; w_data = '0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [31:0] addr,
                            input logic [3:0] strb, input logic sgn);
    r_valid = 1'b1; r_rd = rd; r_addr = addr; r_strb = strb; r_signed = sgn;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] data);
    w_valid = 1'b1; w_addr = addr; w_strb = strb; w_data = data;
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd = rd; e.data = data;
    wb_q.push_back(e);
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata);
    bus_t e;
    e.we = we; e.addr = addr; e.strb = strb; e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  // Single ack-in-first-cycle load: issue, ack, return at the write-back cycle.
  task automatic quick_load(input logic [4:0] rd, input logic [31:0] addr, input logic [3:0] strb,
                            input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
    drive_load(rd, addr, strb, sgn);
    push_bus(1'b0, {addr[31:2], 2'b00}, strb, 32'h0);
    if (rd != 5'd0) push_wb(rd, exp);
    tick();
    clear_inputs();
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    tick();
    bus.mem_ack = 1'b0;
    check("load_wb_latency", 32'(wb_valid), 32'(rd != 5'd0));
    check("load_stall_drop", 32'(stall), 32'd0);
  endtask

  // Write-back scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (wb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected none", wb_rd, wb_data);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_data", wb_data, e.data);
      end
    end
  end

  // Bus transfer scoreboard monitor: one entry per acknowledged request.
  always @(negedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_ack) begin
      if (bus_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL bus_unexpected: got addr=%h we=%0b expected none", bus.mem_addr, bus.mem_we);
      end else begin
        bus_t e;
        e = bus_q.pop_front();
        check("bus_we", 32'(bus.mem_we), 32'(e.we));
        check("bus_addr", bus.mem_addr, e.addr);
        check("bus_strb", 32'(bus.mem_strb), 32'(e.strb));
        if (e.we) check("bus_wdata", bus.mem_wdata, e.wdata);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_req", 32'(bus.mem_req), 32'd0);
    check("reset_err", 32'(bus.mem_err), 32'd0);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain register write forwarded with one-cycle latency, no stall.
    reg_w_valid = 1'b1; reg_w_rd = 5'd5; reg_w_data = 32'h1234;
    push_wb(5'd5, 32'h0000_1234);
    tick();
    clear_inputs();
    check("regw_valid", 32'(wb_valid), 32'd1);
    check("regw_stall", 32'(stall), 32'd0);
    // rd==0 plain write is suppressed.
    reg_w_valid = 1'b1; reg_w_rd = 5'd0; reg_w_data = 32'hDEAD;
    tick();
    clear_inputs();
    check("regw_rd0_valid", 32'(wb_valid), 32'd0);
    tick();

    // Signed byte load in lane 3, ack on third request cycle.
    drive_load(5'd7, 32'h103, 4'b1000, 1'b1);
    push_bus(1'b0, 32'h100, 4'b1000, 32'h0);
    push_wb(5'd7, 32'hFFFF_FF80);
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      check("ld3_stall_high", 32'(stall), 32'd1);
      check("ld3_req_high", 32'(bus.mem_req), 32'd1);
      if (i == 2) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80AA_BBCC;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    check("ld3_stall_low", 32'(stall), 32'd0);
    check("ld3_wb_valid", 32'(wb_valid), 32'd1);
    tick();

    // Assorted loads acked on the first request cycle.
    quick_load(5'd3, 32'h102, 4'b1100, 1'b0, 32'h8001_FFFF, 32'h0000_8001);
    quick_load(5'd10, 32'h100, 4'b0011, 1'b1, 32'h1234_9ABC, 32'hFFFF_9ABC);
    quick_load(5'd11, 32'h101, 4'b0010, 1'b0, 32'h0000_F100, 32'h0000_00F1);
    quick_load(5'd12, 32'h108, 4'b1111, 1'b1, 32'h8765_4321, 32'h8765_4321);
    quick_load(5'd0, 32'h10C, 4'b1111, 1'b0, 32'h1111_1111, 32'h0);
    tick();

    // Store and load together: store first, then load, write-back after second ack.
    drive_store(32'h200, 4'b0011, 32'hBEEF);
    drive_load(5'd9, 32'h204, 4'b1111, 1'b0);
    push_bus(1'b1, 32'h200, 4'b0011, 32'h0000_BEEF);
    push_bus(1'b0, 32'h204, 4'b1111, 32'h0);
    push_wb(5'd9, 32'h1234_5678);
    tick();
    clear_inputs();
    check("sl_wr_we", 32'(bus.mem_we), 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    check("sl_rd_req", 32'(bus.mem_req), 32'd1);
    check("sl_rd_we", 32'(bus.mem_we), 32'd0);
    bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack = 1'b0;
    check("sl_wb_valid", 32'(wb_valid), 32'd1);
    tick();

    // Byte store in lane 2: data shifted into its lane, idle two cycles after sample.
    drive_store(32'h302, 4'b0100, 32'h0000_00A5);
    push_bus(1'b1, 32'h300, 4'b0100, 32'h00A5_0000);
    tick();
    clear_inputs();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("st_idle_stall", 32'(stall), 32'd0);
    check("st_idle_req", 32'(bus.mem_req), 32'd0);
    tick();

    // Timeout in WR with a captured load: load dropped, no write-back.
    drive_store(32'h40, 4'b1111, 32'h1);
    drive_load(5'd8, 32'h44, 4'b1111, 1'b0);
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      check("to_req_high", 32'(bus.mem_req), 32'd1);
      check("to_err_low", 32'(bus.mem_err), 32'd0);
      tick();
    end
    check("to_req_low", 32'(bus.mem_req), 32'd0);
    check("to_err_pulse", 32'(bus.mem_err), 32'd1);
    check("to_stall_low", 32'(stall), 32'd0);
    tick();
    check("to_err_clear", 32'(bus.mem_err), 32'd0);
    check("to_no_wb", 32'(wb_valid), 32'd0);
    tick();

    // Illegal lane masks: error pulse, no bus access, stay idle.
    drive_load(5'd2, 32'h10, 4'b0101, 1'b0);
    tick();
    clear_inputs();
    check("ill_ld_err", 32'(bus.mem_err), 32'd1);
    check("ill_ld_req", 32'(bus.mem_req), 32'd0);
    check("ill_ld_stall", 32'(stall), 32'd0);
    drive_store(32'h10, 4'b0000, 32'h5);
    tick();
    clear_inputs();
    check("ill_st_err", 32'(bus.mem_err), 32'd1);
    check("ill_st_req", 32'(bus.mem_req), 32'd0);
    tick();
    check("ill_err_clear", 32'(bus.mem_err), 32'd0);

    // Asynchronous reset while a read is outstanding.
    drive_load(5'd6, 32'h10, 4'b1111, 1'b0);
    tick();
    clear_inputs();
    check("rst_pre_req", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(bus.mem_req), 32'd0);
    check("rst_stall_drop", 32'(stall), 32'd0);
    check("rst_wb_drop", 32'(wb_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack = 1'b0;
    check("rst_post_req", 32'(bus.mem_req), 32'd0);
    repeat (3) tick();
    check("rst_post_wb", 32'(wb_valid), 32'd0);

    check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
